// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped read-only instruction cache with word-serial line refill
// Hits answer combinationally; misses fetch a full line, then replay as a hit.
module icache_dm #(
  parameter int LINES       = 64,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_IC_DataReq,
  input  logic [31:0] i_IM_Addr,
  output logic        o_IC_MemReady,
  output logic [31:0] o_IM_Instr,
  input  logic        i_flush,
  output logic        o_MEM_Req,
  output logic [31:0] o_MEM_Addr,
  input  logic        i_MEM_Ready,
  input  logic [31:0] i_MEM_Data
);

  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 30 - OB - IB;

  typedef enum logic {S_IDLE, S_REFILL} state_t;

  state_t          state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [OB-1:0]   k_q, k_d, k_inc;
  logic [TB-1:0]   miss_tag_q, miss_tag_d;
  logic [IB-1:0]   miss_idx_q, miss_idx_d;
  logic            flush_pend_q, flush_pend_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic            data_we, tag_we;

  logic [31:0]     data_mem [LINES*BLOCK_WORDS];
  logic [TB-1:0]   tag_mem  [LINES];

  logic [OB-1:0]   req_off;
  logic [IB-1:0]   req_idx;
  logic [TB-1:0]   req_tag;
  logic            hit;
  logic [1:0]      unused_addr_bits;

  assign req_off          = i_IM_Addr[OB+1:2];
  assign req_idx          = i_IM_Addr[OB+IB+1:OB+2];
  assign req_tag          = i_IM_Addr[31:OB+IB+2];
  assign unused_addr_bits = i_IM_Addr[1:0];
  assign k_inc            = k_q + OB'(1);

  // A flush in the same cycle suppresses the hit so the edge-clear is never bypassed.
  assign hit = i_IC_DataReq && (state_q == S_IDLE) && !i_flush &&
               valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  assign o_IC_MemReady = hit;
  assign o_IM_Instr    = hit ? data_mem[{req_idx, req_off}] : 32'h0;
  assign o_MEM_Req     = mem_req_q;
  assign o_MEM_Addr    = mem_addr_q;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    k_d          = k_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    flush_pend_d = flush_pend_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_flush) begin
          valid_d = '0;
        end else if (i_IC_DataReq && !hit) begin
          state_d          = S_REFILL;
          miss_tag_d       = req_tag;
          miss_idx_d       = req_idx;
          valid_d[req_idx] = 1'b0;
          k_d              = '0;
          mem_req_d        = 1'b1;
          mem_addr_d       = {req_tag, req_idx, {OB{1'b0}}, 2'b00};
        end
      end
      S_REFILL: begin
        if (i_flush) flush_pend_d = 1'b1;
        if (i_MEM_Ready) begin
          data_we = 1'b1;
          if (k_q == OB'(BLOCK_WORDS-1)) begin
            tag_we       = 1'b1;
            state_d      = S_IDLE;
            mem_req_d    = 1'b0;
            mem_addr_d   = '0;
            k_d          = '0;
            flush_pend_d = 1'b0;
            // A flush seen at any point of the refill also kills the line just filled.
            if (flush_pend_q || i_flush) valid_d = '0;
            else                         valid_d[miss_idx_q] = 1'b1;
          end else begin
            k_d        = k_inc;
            mem_addr_d = {miss_tag_q, miss_idx_q, k_inc, 2'b00};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      k_q          <= '0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      k_q          <= k_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Arrays keep their contents across reset; only the valid vector is cleared.
  always_ff @(posedge i_clk) begin
    if (data_we) data_mem[{miss_idx_q, k_q}] <= i_MEM_Data;
    if (tag_we)  tag_mem[miss_idx_q]         <= miss_tag_q;
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - directed self-checking bench for icache_dm
// Memory responder with programmable wait states; scenario tasks check inline.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req;
  logic [31:0] im_addr;
  logic        ic_ready;
  logic [31:0] im_instr;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  int          vectors = 0;
  int          miscompares = 0;
  int          mem_wait = 0;
  int          wcnt = 0;
  logic        req_seen = 1'b0;
  logic        addr_unstable = 1'b0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] acc_q[$];
  int          lat;
  logic [31:0] ins;

  icache_dm #(.LINES(64), .BLOCK_WORDS(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_IC_DataReq(ic_req), .i_IM_Addr(im_addr),
    .o_IC_MemReady(ic_ready), .o_IM_Instr(im_instr),
    .i_flush(flush),
    .o_MEM_Req(mem_req), .o_MEM_Addr(mem_addr),
    .i_MEM_Ready(mem_ready), .i_MEM_Data(mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: mem_word = 32'h11;
      32'h104: mem_word = 32'h22;
      32'h108: mem_word = 32'h33;
      32'h10C: mem_word = 32'h44;
      default: mem_word = {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always @(negedge clk) begin
    if (mem_req && req_seen && !mem_ready && mem_addr !== last_addr) addr_unstable = 1'b1;
    last_addr = mem_addr;
    req_seen  = mem_req;
    if (!mem_req) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (mem_ready && mem_wait != 0) begin
      mem_ready = 1'b0;
      wcnt = 1;
    end else if (mem_ready || wcnt >= mem_wait) begin
      mem_ready = 1'b1;
      mem_data  = mem_word(mem_addr);
      acc_q.push_back(mem_addr);
    end else begin
      wcnt++;
    end
  end

  // Entered and left at posedge+1; lat is cycles from request to ready, -1 on timeout.
  task automatic fetch(input logic [31:0] a, output int l, output logic [31:0] d);
    l = -1;
    d = 32'hx;
    im_addr = a;
    ic_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (ic_ready === 1'b1) begin
        l = c;
        d = im_instr;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ic_req = 1'b0;
  endtask

  task automatic wait_ready(output int l, output logic [31:0] d);
    l = -1;
    d = 32'hx;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (ic_ready === 1'b1) begin
        l = c;
        d = im_instr;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ic_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; ic_req = 1'b1; im_addr = 32'h100; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %h exp 0", mem_req); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    vectors++; if (ic_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %h exp 0", ic_ready); end
    vectors++; if (im_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h exp 0", im_instr); end
    ic_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss;
    acc_q.delete();
    fetch(32'h100, lat, ins);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL cold_latency got %0d exp 5", lat); end
    vectors++; if (ins !== 32'h11) begin miscompares++; $display("FAIL cold_instr got %h exp 00000011", ins); end
    vectors++; if (acc_q.size() !== 4) begin miscompares++; $display("FAIL cold_words got %0d exp 4", acc_q.size()); end
    vectors++; if (acc_q[0] !== 32'h100 || acc_q[1] !== 32'h104 || acc_q[2] !== 32'h108 || acc_q[3] !== 32'h10C) begin
      miscompares++; $display("FAIL cold_addr_seq got %h %h %h %h exp 100 104 108 10c", acc_q[0], acc_q[1], acc_q[2], acc_q[3]);
    end
    #1;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL cold_req_drop got %h exp 0", mem_req); end
    fetch(32'h108, lat, ins);
    vectors++; if (lat !== 0) begin miscompares++; $display("FAIL hit_latency got %0d exp 0", lat); end
    vectors++; if (ins !== 32'h33) begin miscompares++; $display("FAIL hit_instr got %h exp 00000033", ins); end
  endtask

  task automatic test_conflict;
    acc_q.delete();
    fetch(32'h1100, lat, ins);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL conflict_latency got %0d exp 5", lat); end
    vectors++; if (ins !== 32'hC0DE1100) begin miscompares++; $display("FAIL conflict_instr got %h exp c0de1100", ins); end
    vectors++; if (acc_q[0] !== 32'h1100 || acc_q[3] !== 32'h110C) begin
      miscompares++; $display("FAIL conflict_addr got %h..%h exp 1100..110c", acc_q[0], acc_q[3]);
    end
    fetch(32'h100, lat, ins);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL conflict_evict got %0d exp 5", lat); end
    vectors++; if (ins !== 32'h11) begin miscompares++; $display("FAIL conflict_refetch got %h exp 00000011", ins); end
  endtask

  task automatic test_wait_states;
    mem_wait = 2;
    addr_unstable = 1'b0;
    acc_q.delete();
    fetch(32'h200, lat, ins);
    vectors++; if (lat !== 13) begin miscompares++; $display("FAIL wait_latency got %0d exp 13", lat); end
    vectors++; if (ins !== 32'hC0DE0200) begin miscompares++; $display("FAIL wait_instr got %h exp c0de0200", ins); end
    vectors++; if (addr_unstable !== 1'b0) begin miscompares++; $display("FAIL wait_addr_stable got %h exp 0", addr_unstable); end
    vectors++; if (acc_q.size() !== 4 || acc_q[1] !== 32'h204 || acc_q[3] !== 32'h20C) begin
      miscompares++; $display("FAIL wait_addr_seq got n=%0d %h %h exp n=4 204 20c", acc_q.size(), acc_q[1], acc_q[3]);
    end
    mem_wait = 0;
    fetch(32'h204, lat, ins);
    vectors++; if (lat !== 0 || ins !== 32'hC0DE0204) begin
      miscompares++; $display("FAIL wait_hit got lat=%0d %h exp lat=0 c0de0204", lat, ins);
    end
  endtask

  task automatic test_flush_refill;
    acc_q.delete();
    ic_req = 1'b1; im_addr = 32'h300;
    @(posedge clk); #1;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(posedge clk); #1; #1;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h30C) begin
      miscompares++; $display("FAIL flush_refill_runs got req=%h addr=%h exp req=1 addr=30c", mem_req, mem_addr);
    end
    @(posedge clk); #1; #1;
    vectors++; if (ic_ready !== 1'b0) begin miscompares++; $display("FAIL flush_refill_line_valid got %h exp 0", ic_ready); end
    wait_ready(lat, ins);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL flush_refill_remiss got %0d exp 5", lat); end
    vectors++; if (ins !== 32'hC0DE0300 || acc_q.size() !== 8) begin
      miscompares++; $display("FAIL flush_refill_data got %h n=%0d exp c0de0300 n=8", ins, acc_q.size());
    end
  endtask

  task automatic test_flush_idle;
    ic_req = 1'b1; im_addr = 32'h300; flush = 1'b1;
    #1;
    vectors++; if (ic_ready !== 1'b0) begin miscompares++; $display("FAIL flush_idle_hit_suppressed got %h exp 0", ic_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    wait_ready(lat, ins);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL flush_idle_after got %0d exp 5", lat); end
    fetch(32'h100, lat, ins);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL flush_idle_line100 got %0d exp 5", lat); end
    fetch(32'h200, lat, ins);
    vectors++; if (lat !== 5 || ins !== 32'hC0DE0200) begin
      miscompares++; $display("FAIL flush_idle_line200 got lat=%0d %h exp lat=5 c0de0200", lat, ins);
    end
  endtask

  task automatic test_drop_req;
    acc_q.delete();
    ic_req = 1'b1; im_addr = 32'h500;
    @(posedge clk); #1;
    im_addr = 32'h100;
    #1;
    vectors++; if (ic_ready !== 1'b0) begin miscompares++; $display("FAIL refill_blocks_hit got %h exp 0", ic_ready); end
    @(posedge clk); #1;
    ic_req = 1'b0;
    #1;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL drop_refill_continues got %h exp 1", mem_req); end
    repeat (3) @(posedge clk);
    #1;
    fetch(32'h504, lat, ins);
    vectors++; if (lat !== 0 || ins !== 32'hC0DE0504) begin
      miscompares++; $display("FAIL drop_line_valid got lat=%0d %h exp lat=0 c0de0504", lat, ins);
    end
    vectors++; if (acc_q.size() !== 4) begin miscompares++; $display("FAIL drop_words got %0d exp 4", acc_q.size()); end
  endtask

  task automatic test_back_to_back;
    ic_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      im_addr = 32'h200 + 32'(4 * i);
      #1;
      vectors++; if (ic_ready !== 1'b1 || im_instr !== (32'hC0DE0200 + 32'(4 * i))) begin
        miscompares++; $display("FAIL b2b_hit%0d got rdy=%h %h exp rdy=1 %h", i, ic_ready, im_instr, 32'hC0DE0200 + 32'(4 * i));
      end
      @(posedge clk); #1;
    end
    ic_req = 1'b0;
  endtask

  task automatic test_reset_mid_refill;
    ic_req = 1'b1; im_addr = 32'h400;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; ic_req = 1'b0;
    @(posedge clk); #1; #1;
    vectors++; if (mem_req !== 1'b0 || ic_ready !== 1'b0 || mem_addr !== 32'h0) begin
      miscompares++; $display("FAIL rst_mid got req=%h rdy=%h addr=%h exp 0 0 0", mem_req, ic_ready, mem_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    acc_q.delete();
    fetch(32'h400, lat, ins);
    vectors++; if (lat !== 5 || ins !== 32'hC0DE0400) begin
      miscompares++; $display("FAIL rst_refetch got lat=%0d %h exp lat=5 c0de0400", lat, ins);
    end
    vectors++; if (acc_q.size() !== 4 || acc_q[0] !== 32'h400 || acc_q[3] !== 32'h40C) begin
      miscompares++; $display("FAIL rst_full_refill got n=%0d %h %h exp n=4 400 40c", acc_q.size(), acc_q[0], acc_q[3]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; ic_req = 1'b0; im_addr = 32'h0; flush = 1'b0;
    mem_ready = 1'b0; mem_data = 32'h0;
    test_reset;
    test_cold_miss;
    test_conflict;
    test_wait_states;
    test_flush_refill;
    test_flush_idle;
    test_drop_req;
    test_back_to_back;
    test_reset_mid_refill;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
